// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message-schedule unit.
// Holds the datapath widths, the round-constant table, the sigma/rotate
// helpers and the schedule FSM state encoding.
package sha256_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DELAY_W = 7;
  localparam int unsigned T_W     = 6;
  localparam int unsigned N_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] x,
                                            input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

endpackage

// File: rtl/xunitm_if.sv
// Versat unit interface for the message-schedule unit.
// master drives run/running/delay0/in0..in15 and observes done/out0/out1;
// slave is the unit side.
interface xunitm_if;
  import sha256_pkg::*;

  logic               running;
  logic               run;
  logic               done;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  in0, in1, in2, in3, in4, in5, in6, in7;
  logic [DATA_W-1:0]  in8, in9, in10, in11, in12, in13, in14, in15;
  logic [DATA_W-1:0]  out0;
  logic [DATA_W-1:0]  out1;

  modport master (
    output running, run, delay0,
    output in0, in1, in2, in3, in4, in5, in6, in7,
    output in8, in9, in10, in11, in12, in13, in14, in15,
    input  done, out0, out1
  );

  modport slave (
    input  running, run, delay0,
    input  in0, in1, in2, in3, in4, in5, in6, in7,
    input  in8, in9, in10, in11, in12, in13, in14, in15,
    output done, out0, out1
  );
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup.
// Ports: addr (round index 0..63) -> data_c (K[addr]).
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [T_W-1:0]    addr,
  output logic [DATA_W-1:0] data_c
);
  assign data_c = K_TABLE[addr];
endmodule

// File: rtl/xunitm.sv
// SHA-256 message-schedule unit: after a start delay it loads a 16-word
// block and emits W_0..W_63 on out0, one per cycle, then holds W_63.
// Ports: clk, rst (sync, active-high), bus (xunitm_if.slave).
// Build option: XUNITM_KROM_EN adds the K ROM and drives K_t on out1;
// otherwise out1 is tied to 0.
module xunitm
  import sha256_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  xunitm_if.slave  bus
);

  state_t             state, state_next;
  logic [DATA_W-1:0]  w [N_WORDS];
  logic [DATA_W-1:0]  msg [N_WORDS];
  logic [DATA_W-1:0]  w_new;
  logic [T_W-1:0]     t, t_next;
  logic [DELAY_W-1:0] delay, delay_next;
  logic               load, shift, done_next, done_q;
  logic               unused_running;

  assign unused_running = bus.running;

  assign msg[0]  = bus.in0;   assign msg[1]  = bus.in1;
  assign msg[2]  = bus.in2;   assign msg[3]  = bus.in3;
  assign msg[4]  = bus.in4;   assign msg[5]  = bus.in5;
  assign msg[6]  = bus.in6;   assign msg[7]  = bus.in7;
  assign msg[8]  = bus.in8;   assign msg[9]  = bus.in9;
  assign msg[10] = bus.in10;  assign msg[11] = bus.in11;
  assign msg[12] = bus.in12;  assign msg[13] = bus.in13;
  assign msg[14] = bus.in14;  assign msg[15] = bus.in15;

  // Next schedule word from the sliding 16-word window.
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; run restarts from any state.
  always_comb begin
    state_next = state;
    if (bus.run) begin
      state_next = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: if (delay == '0) state_next = ST_RUN;
        ST_RUN:  if (t == T_W'(62)) state_next = ST_HOLD;
        default: ;
      endcase
    end
  end

  // Datapath controls and next values of counters/flags.
  always_comb begin
    load       = 1'b0;
    shift      = 1'b0;
    t_next     = t;
    delay_next = delay;
    if (bus.run) begin
      delay_next = bus.delay0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (delay != '0) begin
            delay_next = delay - DELAY_W'(1);
          end else begin
            load   = 1'b1;
            t_next = '0;
          end
        end
        ST_RUN: begin
          shift  = 1'b1;
          t_next = t + T_W'(1);
        end
        default: ;
      endcase
    end
    done_next = (state_next == ST_IDLE) || (state_next == ST_HOLD);
  end

  // Window, counters and done flag; the window is untouched during WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) w[i] <= '0;
      t      <= '0;
      delay  <= '0;
      done_q <= 1'b1;
    end else begin
      t      <= t_next;
      delay  <= delay_next;
      done_q <= done_next;
      if (load) begin
        for (int i = 0; i < N_WORDS; i++) w[i] <= msg[i];
      end else if (shift) begin
        for (int i = 0; i < N_WORDS - 1; i++) w[i] <= w[i+1];
        w[N_WORDS-1] <= w_new;
      end
    end
  end

  assign bus.out0 = w[0];
  assign bus.done = done_q;

`ifdef XUNITM_KROM_EN
  logic [DATA_W-1:0] k_next;
  logic [DATA_W-1:0] out1_q;

  // ROM is addressed by the next count so out1 lines up with out0.
  sha256_k_rom u_k_rom (
    .addr   (t_next),
    .data_c (k_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_q <= '0;
    end else if (state_next == ST_RUN || state_next == ST_HOLD) begin
      out1_q <= k_next;
    end else begin
      out1_q <= '0;
    end
  end

  assign bus.out1 = out1_q;
`else
  assign bus.out1 = '0;
`endif

endmodule

// File: tb/tb_xunitm.sv
module tb_xunitm;

  logic clk;
  logic rst;
  xunitm_if bus ();

  xunitm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] K_FIRST = 32'h428A2F98;
  localparam logic [31:0] K_LAST  = 32'hC67178F2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];
  logic [31:0] exp_prev;

  typedef struct {
    string       name;
    logic [31:0] m0;
    logic [31:0] m15;
    int          d;
    logic [31:0] w0, w16, w17, w63;
  } vec_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Textbook SHA-256 message expansion over a 64-entry array.
  task automatic build_model(input logic [31:0] m [16]);
    for (int i = 0; i < 16; i++) exp_w[i] = m[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.running = 1'($urandom);
  endtask

  task automatic drive_block(input logic [31:0] m [16]);
    bus.in0  = m[0];  bus.in1  = m[1];  bus.in2  = m[2];  bus.in3  = m[3];
    bus.in4  = m[4];  bus.in5  = m[5];  bus.in6  = m[6];  bus.in7  = m[7];
    bus.in8  = m[8];  bus.in9  = m[9];  bus.in10 = m[10]; bus.in11 = m[11];
    bus.in12 = m[12]; bus.in13 = m[13]; bus.in14 = m[14]; bus.in15 = m[15];
  endtask

  task automatic drive_garbage();
    logic [31:0] g [16];
    for (int i = 0; i < 16; i++) g[i] = $urandom;
    drive_block(g);
  endtask

  function automatic logic [31:0] exp_k(input int n);
`ifdef XUNITM_KROM_EN
    if (n == 0) return K_FIRST;
    return K_LAST;
`else
    if (n < 0) return 32'hx;
    return 32'h0;
`endif
  endfunction

  function automatic bit k_known(input int n);
`ifdef XUNITM_KROM_EN
    return (n == 0) || (n == 63);
`else
    return n >= 0;
`endif
  endfunction

  // Pulse run with block m and delay d; follow the schedule to W_63 plus a
  // few HOLD cycles, or stop right after observing word abort_at.
  task automatic run_schedule(input logic [31:0] m [16], input int d,
                              input int abort_at);
    build_model(m);
    drive_block(m);
    bus.delay0 = 7'(d);
    bus.run    = 1'b1;
    tick();
    bus.run    = 1'b0;
    for (int i = 0; i <= d; i++) begin
      check("wait_out0", i, bus.out0, exp_prev);
      check("wait_done", i, 32'(bus.done), 32'h0);
      check("wait_out1", i, bus.out1, 32'h0);
      tick();
    end
    drive_garbage();
    for (int n = 0; n < 64; n++) begin
      obs_w[n] = bus.out0;
      check("w", n, bus.out0, exp_w[n]);
      exp_prev = exp_w[n];
      check("run_done", n, 32'(bus.done), (n == 63) ? 32'h1 : 32'h0);
      if (k_known(n)) check("k", n, bus.out1, exp_k(n));
      if (n == abort_at) return;
      if (n < 63) tick();
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_out0", i, bus.out0, exp_w[63]);
      check("hold_done", i, 32'(bus.done), 32'h1);
      check("hold_out1", i, bus.out1, exp_k(63));
    end
  endtask

  initial begin
    vec_t        tbl [4];
    logic [31:0] blk [16];
    logic [31:0] zblk [16];

    tbl[0] = '{"abc_d0", 32'h61626380, 32'h18, 0,
               32'h61626380, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};
    tbl[1] = '{"abc_d5", 32'h61626380, 32'h18, 5,
               32'h61626380, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};
    tbl[2] = '{"zero_d0", 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{"abc_d2", 32'h61626380, 32'h18, 2,
               32'h61626380, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};
    for (int i = 0; i < 16; i++) zblk[i] = 32'h0;

    // Reset with all inputs high, then idle with no run.
    rst = 1'b1;
    bus.run = 1'b0;
    bus.running = 1'b0;
    bus.delay0 = 7'd0;
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    drive_block(blk);
    tick();
    check("rst_out0", 0, bus.out0, 32'h0);
    check("rst_out1", 0, bus.out1, 32'h0);
    check("rst_done", 0, 32'(bus.done), 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_out0", i, bus.out0, 32'h0);
      check("idle_out1", i, bus.out1, 32'h0);
      check("idle_done", i, 32'(bus.done), 32'h1);
    end
    exp_prev = 32'h0;

    // Known-answer table.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = tbl[v].m0;
      blk[15] = tbl[v].m15;
      run_schedule(blk, tbl[v].d, -1);
      check({tbl[v].name, "_w0"},  0,  obs_w[0],  tbl[v].w0);
      check({tbl[v].name, "_w16"}, 16, obs_w[16], tbl[v].w16);
      check({tbl[v].name, "_w17"}, 17, obs_w[17], tbl[v].w17);
      check({tbl[v].name, "_w63"}, 63, obs_w[63], tbl[v].w63);
    end

    // Random blocks and delays against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_schedule(blk, int'($urandom_range(0, 7)), -1);
    end

    // Restart at t=30 with an all-zero block: no leftover words.
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_schedule(blk, 0, 30);
    run_schedule(zblk, 0, -1);

    // Run coinciding with the t==62 -> HOLD transition: run wins.
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_schedule(blk, 1, 62);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_schedule(blk, 3, -1);

    // Synchronous reset at t=40, then a clean schedule.
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_schedule(blk, 0, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out0", 0, bus.out0, 32'h0);
    check("midrst_out1", 0, bus.out1, 32'h0);
    check("midrst_done", 0, 32'(bus.done), 32'h1);
    exp_prev = 32'h0;

    // rst together with run: rst wins, unit stays idle.
    rst = 1'b1;
    bus.run = 1'b1;
    tick();
    rst = 1'b0;
    bus.run = 1'b0;
    check("rstrun_done", 0, 32'(bus.done), 32'h1);
    tick();
    check("rstrun_done", 1, 32'(bus.done), 32'h1);
    check("rstrun_out0", 1, bus.out0, 32'h0);

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_schedule(blk, 4, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
